// File: rtl/ureg_arbiter_if.sv
// ----------------------------------------------------------------------------
// ureg_arbiter_if
// Purpose : bundles the two requester command/ack handshakes and the shared
//           universal-register control bus driven by ureg_arbiter.
// Signals : req0/op0/data0/cnt0 -> command from requester 0, ack0 <- completion
//           req1/op1/data1/cnt1 -> command from requester 1, ack1 <- completion
//           s1/s0/d             <- register mode select and load data
//           busy/owner          <- command in flight / granted requester index
// Modports: master = requester side (drives commands)
//           slave  = arbiter side (drives acks and the register bus)
// ----------------------------------------------------------------------------
interface ureg_arbiter_if #(
   parameter int CW = 3
);
   logic          req0;
   logic [1:0]    op0;
   logic [3:0]    data0;
   logic [CW-1:0] cnt0;
   logic          ack0;

   logic          req1;
   logic [1:0]    op1;
   logic [3:0]    data1;
   logic [CW-1:0] cnt1;
   logic          ack1;

   logic          s1;
   logic          s0;
   logic [3:0]    d;
   logic          busy;
   logic          owner;

   modport master (
      output req0, op0, data0, cnt0,
      output req1, op1, data1, cnt1,
      input  ack0, ack1, s1, s0, d, busy, owner
   );

   modport slave (
      input  req0, op0, data0, cnt0,
      input  req1, op1, data1, cnt1,
      output ack0, ack1, s1, s0, d, busy, owner
   );
endinterface

// File: rtl/ureg_arbiter.sv
// ----------------------------------------------------------------------------
// ureg_arbiter
// Purpose : shares one 4-bit universal register between two requesters.
//           Each command (op, load data, repeat count) is granted round-robin,
//           its op is driven on s1/s0/d for cnt+1 cycles, then the owner gets
//           a one-cycle ack.
// Ports   : c    - clock, all state changes on the rising edge
//           rst  - synchronous active-high reset
//           bus  - ureg_arbiter_if.slave (req/op/data/cnt in, ack/s1/s0/d/
//                  busy/owner out, all outputs registered)
// Params  : CW   - repeat-count width; an op is applied 1..2^CW times
// Options : define UREG_ARBITER_CLEAR_ON_RESET_EN to insert a one-cycle INIT
//           state after reset that drives CLEAR so the register reads 0000
//           in the first IDLE cycle. Without it reset goes straight to IDLE
//           and the register keeps its contents.
// ----------------------------------------------------------------------------
module ureg_arbiter #(
   parameter int CW = 3
) (
   input  logic          c,
   input  logic          rst,
   ureg_arbiter_if.slave bus
);

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ACK  = 2'd2,
      ST_INIT = 2'd3
   } state_t;

   state_t        state_q;
   logic [CW-1:0] rem_q;     // EXEC edges still to go after the current one
   logic          owner_q;
   logic          last_q;    // last-served requester
   logic          s1_q;
   logic          s0_q;
   logic [3:0]    d_q;
   logic          busy_q;
   logic          ack0_q;
   logic          ack1_q;

   logic          owner_d;
   logic [1:0]    op_d;
   logic [3:0]    data_d;
   logic [CW-1:0] cnt_d;

   // Pick the winner and capture its command; data is forced to 0 unless LOAD.
   always_comb begin
      owner_d = 1'b0;
      op_d    = OP_HOLD;
      data_d  = 4'd0;
      cnt_d   = {CW{1'b0}};
      if (bus.req0 && bus.req1) begin
         // tie: the requester that was not served last goes first
         owner_d = ~last_q;
      end else begin
         owner_d = bus.req1;
      end
      if (owner_d) begin
         op_d  = bus.op1;
         cnt_d = bus.cnt1;
         if (bus.op1 == OP_LOAD) begin
            data_d = bus.data1;
         end else begin
            data_d = 4'd0;
         end
      end else begin
         op_d  = bus.op0;
         cnt_d = bus.cnt0;
         if (bus.op0 == OP_LOAD) begin
            data_d = bus.data0;
         end else begin
            data_d = 4'd0;
         end
      end
   end

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge c) begin
      if (rst) begin
`ifdef UREG_ARBITER_CLEAR_ON_RESET_EN
         state_q <= ST_INIT;
         s1_q    <= 1'b1;
         busy_q  <= 1'b1;
`else
         state_q <= ST_IDLE;
         s1_q    <= 1'b0;
         busy_q  <= 1'b0;
`endif
         s0_q    <= 1'b0;
         d_q     <= 4'd0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         rem_q   <= {CW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack0_q <= 1'b0;
               ack1_q <= 1'b0;
               if (bus.req0 || bus.req1) begin
                  state_q <= ST_EXEC;
                  owner_q <= owner_d;
                  last_q  <= owner_d;
                  rem_q   <= cnt_d;
                  s1_q    <= op_d[1];
                  s0_q    <= op_d[0];
                  d_q     <= data_d;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  s1_q    <= 1'b0;
                  s0_q    <= 1'b0;
                  d_q     <= 4'd0;
                  busy_q  <= 1'b0;
               end
            end
            ST_EXEC: begin
               if (rem_q == {CW{1'b0}}) begin
                  state_q <= ST_ACK;
                  s1_q    <= 1'b0;
                  s0_q    <= 1'b0;
                  d_q     <= 4'd0;
                  busy_q  <= 1'b1;
                  ack0_q  <= ~owner_q;
                  ack1_q  <= owner_q;
               end else begin
                  // decrement only when nonzero, so rem_q never wraps
                  rem_q   <= rem_q - CW'(1'b1);
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               busy_q  <= 1'b0;
               s1_q    <= 1'b0;
               s0_q    <= 1'b0;
               d_q     <= 4'd0;
            end
            ST_INIT: begin
               // one CLEAR cycle is enough; requests wait for IDLE
               state_q <= ST_IDLE;
               s1_q    <= 1'b0;
               s0_q    <= 1'b0;
               d_q     <= 4'd0;
               busy_q  <= 1'b0;
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               s1_q    <= 1'b0;
               s0_q    <= 1'b0;
               d_q     <= 4'd0;
               busy_q  <= 1'b0;
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s1    = s1_q;
   assign bus.s0    = s0_q;
   assign bus.d     = d_q;
   assign bus.busy  = busy_q;
   assign bus.owner = owner_q;
   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;

endmodule

// File: tb/tb_ureg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ureg_arbiter
// Drives ureg_arbiter through per-requester command queues, attaches a real
// 4-bit universal register to s1/s0/d, and compares every cycle against a
// transaction-level model (grant edge + cycle offsets). Directed scenarios
// add literal expectations for register contents, ack order and latency.
// ----------------------------------------------------------------------------
module tb_ureg_arbiter;
   localparam int CW = 3;

   typedef struct packed {
      logic [1:0]    op;
      logic [3:0]    data;
      logic [CW-1:0] cnt;
   } cmd_t;

   logic c   = 1'b0;
   logic rst = 1'b1;
   always #5 c = ~c;

   ureg_arbiter_if #(.CW(CW)) bus();
   ureg_arbiter #(.CW(CW)) dut (.c(c), .rst(rst), .bus(bus.slave));

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic cmd_t mk(input logic [1:0] op, input logic [3:0] dat, input logic [CW-1:0] n);
      cmd_t r;
      r.op = op; r.data = dat; r.cnt = n;
      return r;
   endfunction

   // Register value after applying op n times to v.
   function automatic logic [3:0] apply_n(input logic [3:0] v, input logic [1:0] op,
                                          input logic [3:0] dat, input int n);
      case (op)
         2'b00:   return v;
         2'b01:   return (n % 2 == 1) ? ~v : v;
         2'b10:   return 4'd0;
         default: return dat;
      endcase
   endfunction

   // Universal register attached to the arbiter outputs.
   logic [3:0] ureg_q = 4'd0;
   always @(posedge c) begin
      case ({bus.s1, bus.s0})
         2'b00:   ureg_q <= ureg_q;
         2'b01:   ureg_q <= ~ureg_q;
         2'b10:   ureg_q <= 4'd0;
         default: ureg_q <= bus.d;
      endcase
   end

   // ---------------- transaction-level model ----------------
   bit         m_valid = 1'b0;
   bit         m_active = 1'b0;
   int         m_g = 0, m_cnt = 0, m_idle_from = 0;
   logic       m_who = 1'b0, m_ptr = 1'b1;
   logic [1:0] m_op = 2'b00;
   logic [3:0] m_data = 4'd0, m_final = 4'd0;
   logic [1:0] e_s;
   logic [3:0] e_d;
   logic       e_busy, e_owner, e_ack0, e_ack1, e_regchk;

   always @(posedge c) begin : model
      int e;
      e = cyc;
      if (rst) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_ptr    = 1'b1;
`ifdef UREG_ARBITER_CLEAR_ON_RESET_EN
         m_idle_from = e + 2;
`else
         m_idle_from = e + 1;
`endif
      end else begin
         if (m_active && e >= m_g + m_cnt + 2) m_active = 1'b0;
         if (!m_active && e >= m_idle_from && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) m_who = ~m_ptr;
            else                      m_who = bus.req1;
            m_op   = m_who ? bus.op1 : bus.op0;
            m_data = m_who ? bus.data1 : bus.data0;
            m_cnt  = int'(m_who ? bus.cnt1 : bus.cnt0);
            m_final = apply_n(ureg_q, m_op, m_data, m_cnt + 1);
            m_g = e;
            m_active = 1'b1;
            m_ptr = m_who;
            m_idle_from = e + m_cnt + 3;
         end
      end
      e_s = 2'b00; e_d = 4'd0; e_busy = 1'b0; e_owner = 1'b0;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_regchk = 1'b0;
      if (rst) begin
`ifdef UREG_ARBITER_CLEAR_ON_RESET_EN
         e_s = 2'b10;
         e_busy = 1'b1;
`endif
      end else if (m_active) begin
         e_owner = m_who;
         if (e <= m_g + m_cnt) begin
            e_s = m_op;
            e_d = (m_op == 2'b11) ? m_data : 4'd0;
            e_busy = 1'b1;
         end else if (e == m_g + m_cnt + 1) begin
            e_busy = 1'b1;
            e_ack0 = ~m_who;
            e_ack1 = m_who;
            e_regchk = 1'b1;
         end
      end
      cyc = cyc + 1;
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge c) begin
      if (m_valid) begin
         chk("s1s0", {6'd0, bus.s1, bus.s0}, {6'd0, e_s});
         chk("d", {4'd0, bus.d}, {4'd0, e_d});
         chk("busy", {7'd0, bus.busy}, {7'd0, e_busy});
         chk("ack0", {7'd0, bus.ack0}, {7'd0, e_ack0});
         chk("ack1", {7'd0, bus.ack1}, {7'd0, e_ack1});
         if (e_busy) chk("owner", {7'd0, bus.owner}, {7'd0, e_owner});
         if (e_regchk) chk("reg_at_ack", {4'd0, ureg_q}, {4'd0, m_final});
      end
   end

   // ---------------- requesters ----------------
   cmd_t       q0[$], q1[$];
   logic       ack_who[$];
   logic [3:0] ack_reg[$];
   int         t0 = 0, t1 = 0, lat0 = 0, lat1 = 0;

   initial begin
      bus.req0 = 1'b0; bus.op0 = 2'b00; bus.data0 = 4'd0; bus.cnt0 = '0;
      forever begin
         @(negedge c);
         if (bus.ack0) begin
            if (q0.size() > 0) q0.delete(0);
            lat0 = cyc - t0;
            ack_who.push_back(1'b0);
            ack_reg.push_back(ureg_q);
         end
         if (q0.size() > 0) begin
            if (!bus.req0 || bus.ack0) t0 = cyc;
            bus.req0 = 1'b1; bus.op0 = q0[0].op; bus.data0 = q0[0].data; bus.cnt0 = q0[0].cnt;
         end else begin
            bus.req0 = 1'b0;
         end
      end
   end

   initial begin
      bus.req1 = 1'b0; bus.op1 = 2'b00; bus.data1 = 4'd0; bus.cnt1 = '0;
      forever begin
         @(negedge c);
         if (bus.ack1) begin
            if (q1.size() > 0) q1.delete(0);
            lat1 = cyc - t1;
            ack_who.push_back(1'b1);
            ack_reg.push_back(ureg_q);
         end
         if (q1.size() > 0) begin
            if (!bus.req1 || bus.ack1) t1 = cyc;
            bus.req1 = 1'b1; bus.op1 = q1[0].op; bus.data1 = q1[0].data; bus.cnt1 = q1[0].cnt;
         end else begin
            bus.req1 = 1'b0;
         end
      end
   end

   task automatic wait_acks(input int n);
      int k;
      k = 0;
      while (ack_who.size() < n && k < 300) begin
         @(posedge c);
         k++;
      end
      chk("ack_count", 8'(ack_who.size()), 8'(n));
      @(posedge c);
      #2;
   endtask

   task automatic pulse_rst();
      @(posedge c); #2 rst = 1'b1;
      @(posedge c); #2 rst = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int k;
      rst = 1'b1;
      repeat (2) @(posedge c);
      #2 rst = 1'b0;
      @(negedge c);
`ifdef UREG_ARBITER_CLEAR_ON_RESET_EN
      chk("rst_init_mode", {6'd0, bus.s1, bus.s0}, 8'h02);
      chk("rst_init_busy", {7'd0, bus.busy}, 8'h01);
      @(negedge c);
`endif
      chk("rst_busy", {7'd0, bus.busy}, 8'h00);
      chk("rst_owner", {7'd0, bus.owner}, 8'h00);
      chk("rst_mode", {6'd0, bus.s1, bus.s0}, 8'h00);
      @(posedge c); #2;

      // single LOAD 1010
      q0.push_back(mk(2'b11, 4'b1010, 3'd0));
      wait_acks(1);
      chk("load_reg", {4'd0, ack_reg[0]}, 8'h0A);
      chk("load_lat", 8'(lat0), 8'd2);

      // requester 1: LOAD 0101 then INVERT x3
      q1.push_back(mk(2'b11, 4'b0101, 3'd0));
      wait_acks(2);
      q1.push_back(mk(2'b01, 4'b0000, 3'd2));
      wait_acks(3);
      chk("inv_reg", {4'd0, ack_reg[2]}, 8'h0A);
      chk("inv_lat", 8'(lat1), 8'd4);
      chk("inv_who", {7'd0, ack_who[2]}, 8'h01);

      // tie from reset, then strict alternation
      pulse_rst();
      q0.push_back(mk(2'b11, 4'b0011, 3'd0));
      q0.push_back(mk(2'b11, 4'b0110, 3'd1));
      q1.push_back(mk(2'b11, 4'b1100, 3'd0));
      q1.push_back(mk(2'b11, 4'b1001, 3'd0));
      wait_acks(7);
      chk("tie_who0", {7'd0, ack_who[3]}, 8'h00);
      chk("tie_who1", {7'd0, ack_who[4]}, 8'h01);
      chk("tie_who2", {7'd0, ack_who[5]}, 8'h00);
      chk("tie_who3", {7'd0, ack_who[6]}, 8'h01);
      chk("tie_reg0", {4'd0, ack_reg[3]}, 8'h03);
      chk("tie_reg1", {4'd0, ack_reg[4]}, 8'h0C);
      chk("tie_reg2", {4'd0, ack_reg[5]}, 8'h06);
      chk("tie_reg3", {4'd0, ack_reg[6]}, 8'h09);

      // reset in the third EXEC cycle of a long INVERT
      q0.push_back(mk(2'b01, 4'b0000, 3'd7));
      k = 0;
      do begin
         @(negedge c);
         k++;
      end while (!bus.busy && k < 20);
      chk("exec_started", {7'd0, bus.busy}, 8'h01);
      @(posedge c);
      @(posedge c);
      #2 rst = 1'b1;
      q0.delete();
      @(posedge c); #2 rst = 1'b0;
      @(negedge c);
`ifdef UREG_ARBITER_CLEAR_ON_RESET_EN
      chk("midrst_mode", {6'd0, bus.s1, bus.s0}, 8'h02);
`else
      chk("midrst_mode", {6'd0, bus.s1, bus.s0}, 8'h00);
      chk("midrst_busy", {7'd0, bus.busy}, 8'h00);
`endif
      repeat (4) @(negedge c);
      chk("midrst_no_ack", 8'(ack_who.size()), 8'd7);
      @(posedge c); #2;
      q0.push_back(mk(2'b11, 4'b0111, 3'd0));
      wait_acks(8);
      chk("after_rst_reg", {4'd0, ack_reg[7]}, 8'h07);
      chk("after_rst_lat", 8'(lat0), 8'd2);

      // HOLD then CLEAR
      q0.push_back(mk(2'b11, 4'b1111, 3'd0));
      wait_acks(9);
      q0.push_back(mk(2'b00, 4'b0000, 3'd1));
      wait_acks(10);
      chk("hold_reg", {4'd0, ack_reg[9]}, 8'h0F);
      chk("hold_lat", 8'(lat0), 8'd3);
      q0.push_back(mk(2'b10, 4'b0000, 3'd0));
      wait_acks(11);
      chk("clear_reg", {4'd0, ack_reg[10]}, 8'h00);

      // reset behaviour of the attached register
      q0.push_back(mk(2'b11, 4'b0110, 3'd0));
      wait_acks(12);
      chk("preload_reg", {4'd0, ack_reg[11]}, 8'h06);
      @(posedge c); #2 rst = 1'b1;
`ifdef UREG_ARBITER_CLEAR_ON_RESET_EN
      q0.push_back(mk(2'b11, 4'b1001, 3'd0));
      @(posedge c); #2 rst = 1'b0;
      @(negedge c);
      chk("init_mode", {6'd0, bus.s1, bus.s0}, 8'h02);
      chk("init_busy", {7'd0, bus.busy}, 8'h01);
      chk("init_req_held", {7'd0, bus.req0}, 8'h01);
      @(negedge c);
      chk("init_reg_zero", {4'd0, ureg_q}, 8'h00);
      chk("init_idle_busy", {7'd0, bus.busy}, 8'h00);
      wait_acks(13);
      chk("init_then_load", {4'd0, ack_reg[12]}, 8'h09);
`else
      @(posedge c); #2 rst = 1'b0;
      @(negedge c);
      chk("rst_keeps_reg", {4'd0, ureg_q}, 8'h06);
      chk("rst_idle_busy", {7'd0, bus.busy}, 8'h00);
`endif

      repeat (3) @(posedge c);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/ureg_arbiter.md
Name: ureg_arbiter

Overview:
- Sequencer/arbiter sharing one 4-bit universal register between two requesters.
- The register is driven by mode selects s1,s0 and load data d.
- Each requester submits one command over a req/ack handshake. A command is an operation, load data and a repeat count.
- The block grants requesters round-robin, drives s1/s0/d for the required number of cycles, then acknowledges.

Parameters:
- CW, 3, width of repeat-count field. The op is applied cnt+1 times, so 1..2^CW applications.

Ports:
- c  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 command request
- op0  input  2  requester 0 operation: 00 HOLD, 01 INVERT, 10 CLEAR, 11 LOAD
- data0  input  4  requester 0 load data, used only for LOAD
- cnt0  input  CW  requester 0 repeat count
- ack0  output  1  requester 0 completion pulse
- req1, op1, data1, cnt1, ack1  same as requester 0, for requester 1
- s1  output  1  register mode select, high bit
- s0  output  1  register mode select, low bit
- d  output  4  register load data
- busy  output  1  high while a command is in flight
- owner  output  1  index of granted requester; meaningful only while busy=1

Behaviour:
- All outputs are registered.
- Reset values: s1=0, s0=0, d=0, ack0=0, ack1=0, busy=0, owner=0. Round-robin last-served pointer = 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, ACK (plus INIT when the optional feature is enabled).
- IDLE:
  - Drives HOLD (s1s0=00), d=0, busy=0.
  - At an edge where any req is high: choose the winner, latch its op/data/cnt into internal regs, set owner, set remaining=cnt, go to EXEC.
  - Arbitration: a single requester wins outright. If both request, the winner is the one not equal to the last-served pointer.
  - The pointer updates to the winner at grant.
- EXEC:
  - s1s0 = latched op, d = latched data (0 unless LOAD), busy=1.
  - The register applies the op at each edge spent in EXEC.
  - At each edge, if remaining==0 go to ACK; else remaining decrements.
  - Result: exactly cnt+1 edges with the op applied.
- ACK:
  - s1s0=00, d=0, busy=1.
  - ack of owner = 1 for exactly this one cycle; the other ack = 0.
  - Next state is IDLE unconditionally.
- Handshake:
  - Requester holds req/op/data/cnt stable from assertion until it sees ack.
  - It deasserts req at the edge ending the ack cycle.
  - A req still high in the IDLE cycle after ACK is a new command.
  - Reqs are ignored outside IDLE, so there are no pre-grants.
- Latency:
  - req seen at edge k → mode on outputs during cycles k+1..k+cnt+1.
  - ack in cycle k+cnt+2.
  - IDLE in cycle k+cnt+3.
  - Minimum back-to-back command spacing is cnt+3 cycles.
- op=HOLD commands are legal: granted normally, occupy cnt+1 cycles with s1s0=00, then acked.
- CLEAR/LOAD with cnt>0 are legal; they are idempotent but still occupy cnt+1 cycles.
- Loser of a tie keeps req high and is granted at the next IDLE. It is guaranteed service before the winner's next command.
- Reset mid-operation (EXEC or ACK):
  - Next state IDLE (or INIT), outputs to reset values, no ack issued, pointer reset.
  - The interrupted command is dropped; the requester must reissue it.
  - Register contents are not restored.
- cnt width arithmetic: remaining is CW bits and never underflows, because the decrement happens only when nonzero.

Optional Feature:
- Macro: UREG_ARBITER_CLEAR_ON_RESET_EN.
- Defined:
  - Reset enters INIT. INIT drives s1s0=10, d=0, busy=1, no ack for exactly one cycle, then goes to IDLE.
  - Attached register is 0000 on the first IDLE cycle after reset.
  - Reqs are ignored in INIT.
- Undefined: reset goes directly to IDLE; register contents after reset are whatever they were.

Test Plan:
- Bench attaches a real 4-bit universal register to s1/s0/d.
- Single LOAD: req0, op0=11, data0=1010, cnt0=0 at edge k → s1s0=11, d=1010 in cycle k+1; register=1010 after; ack0=1 in cycle k+2 only; busy low in k+3.
- Repeated INVERT: register=0101, req1, op1=01, cnt1=2 → three toggles, register=1010; ack1 at k+4; owner=1 throughout busy.
- Tie and fairness: both req from reset, op0=LOAD 0011, op1=LOAD 1100, cnt=0 → requester 0 first (register 0011, ack0), then requester 1 (register 1100, ack1). Keep both requesting → strict alternation 0,1,0,1.
- Reset mid-EXEC: req0, op0=INVERT, cnt0=7, rst asserted in 3rd EXEC cycle → next cycle s1s0=00, busy=0, no ack0 ever. A fresh req0 after reset is granted normally.
- HOLD and CLEAR: register=1111, op0=HOLD, cnt0=1 → register stays 1111, ack0 at k+3. Then op0=CLEAR, cnt0=0 → register 0000.
- With UREG_ARBITER_CLEAR_ON_RESET_EN: preload register 0110, pulse rst → one cycle s1s0=10 with busy=1, register=0000 in the first IDLE cycle. A req held high during INIT is granted only in IDLE.
